bit1_master: RTL and testbench



---
 rtl/bit1_pkg.sv | 26 ++
 rtl/bit1_master_if.sv | 29 ++
 rtl/bit1_master.sv | 177 +++++++++++++++++
 tb/tb_bit1_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit1_pkg.sv
// Shared constants and types for the bit1 PIO initiator:
// register map addresses, command op-codes and FSM states.
package bit1_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  localparam logic [1:0] OP_SET_DIR = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_READ    = 2'd2;
  localparam logic [1:0] OP_PULSE   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_CAP   = 3'd3,
    S_PSET  = 3'd4,
    S_PHOLD = 3'd5,
    S_PCLR  = 3'd6,
    S_RSP   = 3'd7
  } state_t;

endpackage

// File: rtl/bit1_master_if.sv
// Command/response handshake plus Avalon-MM bus towards the bit1 PIO.
// The master modport is the initiator's view; slave is the environment's.
interface bit1_master_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_data;
  logic [2:0]       m_address;
  logic             m_chipselect;
  logic             m_write_n;
  logic [31:0]      m_writedata;
  logic [31:0]      m_readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, m_readdata,
    output cmd_ready, rsp_valid, rsp_data,
           m_address, m_chipselect, m_write_n, m_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, m_readdata,
    input  cmd_ready, rsp_valid, rsp_data,
           m_address, m_chipselect, m_write_n, m_writedata
  );
endinterface

// File: rtl/bit1_master.sv
// Avalon-MM initiator for a single-bit PIO. Turns local commands
// (set direction, write, read, timed pulse) into register accesses.
// Every output is registered: the next-cycle value is decoded from the
// next state, so the bus never glitches. One down-counter serves both
// the read-latency wait and the pulse hold time.
module bit1_master
  import bit1_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  bit1_master_if.master bus
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_op, w_op;
  logic [CNT_W-1:0] r_data, w_data;
  logic             w_accept;

  logic             r_cmd_ready, w_cmd_ready;
  logic             r_rsp_valid, w_rsp_valid;
  logic             r_rsp_data, w_rsp_data;
  logic [2:0]       r_address, w_address;
  logic             r_chipselect, w_chipselect;
  logic             r_write_n, w_write_n;
  logic [31:0]      r_writedata, w_writedata;

  // Command handshake; the op/data of an accepting edge are used directly
  // so the first bus cycle can be driven straight out of IDLE.
  always_comb begin
    w_accept = bus.cmd_valid && r_cmd_ready && (r_state == S_IDLE);
    if (w_accept) begin
      w_op   = bus.cmd_op;
      w_data = bus.cmd_data;
    end else begin
      w_op   = r_op;
      w_data = r_data;
    end
  end

  // Next-state and shared down-counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_SET_DIR, OP_WRITE: w_state_nxt = S_WR;
            OP_READ: begin
              w_state_nxt = S_RD;
              w_cnt_nxt   = CNT_W'(READ_LATENCY - 1);
            end
            OP_PULSE: w_state_nxt = S_PSET;
            default:  w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR:  w_state_nxt = S_RSP;
      S_RD: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_CAP;
        end else begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_CAP: w_state_nxt = S_RSP;
      S_PSET: begin
        // Lengths 0 and 1 both give a single high cycle (PSET->PCLR).
        if (r_data > {{(CNT_W-1){1'b0}}, 1'b1}) begin
          w_state_nxt = S_PHOLD;
          w_cnt_nxt   = r_data - CNT_W'(2);
        end else begin
          w_state_nxt = S_PCLR;
        end
      end
      S_PHOLD: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_PCLR;
        end else begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_PCLR:  w_state_nxt = S_RSP;
      S_RSP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decode next-cycle outputs from the next state (bus idle by default).
  always_comb begin
    w_cmd_ready  = (w_state_nxt == S_IDLE);
    w_rsp_valid  = (w_state_nxt == S_RSP);
    w_address    = 3'd0;
    w_chipselect = 1'b0;
    w_write_n    = 1'b1;
    w_writedata  = 32'd0;
    case (w_state_nxt)
      S_WR: begin
        w_chipselect = 1'b1;
        w_write_n    = 1'b0;
        w_address    = (w_op == OP_SET_DIR) ? ADDR_DIR : ADDR_DATA;
        w_writedata  = {31'd0, w_data[0]};
      end
      S_RD, S_CAP: begin
        w_chipselect = 1'b1;
        w_address    = ADDR_DATA;
      end
      S_PSET: begin
        w_chipselect = 1'b1;
        w_write_n    = 1'b0;
        w_address    = ADDR_SET;
        w_writedata  = 32'd1;
      end
      S_PCLR: begin
        w_chipselect = 1'b1;
        w_write_n    = 1'b0;
        w_address    = ADDR_CLR;
        w_writedata  = 32'd1;
      end
      default: begin
        w_chipselect = 1'b0;
      end
    endcase
    // Read value captured at the end of CAP; cleared by any other op.
    if (r_state == S_CAP) begin
      w_rsp_data = bus.m_readdata[0];
    end else if ((r_state == S_WR) || (r_state == S_PCLR)) begin
      w_rsp_data = 1'b0;
    end else begin
      w_rsp_data = r_rsp_data;
    end
  end

  // State, counter, latched command and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_op         <= 2'd0;
      r_data       <= {CNT_W{1'b0}};
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 1'b0;
      r_address    <= 3'd0;
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_writedata  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_op         <= w_op;
      r_data       <= w_data;
      r_cmd_ready  <= w_cmd_ready;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_data   <= w_rsp_data;
      r_address    <= w_address;
      r_chipselect <= w_chipselect;
      r_write_n    <= w_write_n;
      r_writedata  <= w_writedata;
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.m_address    = r_address;
  assign bus.m_chipselect = r_chipselect;
  assign bus.m_write_n    = r_write_n;
  assign bus.m_writedata  = r_writedata;

endmodule

// File: tb/tb_bit1_master.sv
// Bench for bit1_master: two instances (read latency 1 and 3) each on a
// behavioural bit1 PIO model. Accepted commands push expected responses
// into a scoreboard; a negedge monitor pops and compares on rsp_valid.
module tb_bit1_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bit1_master_if #(.CNT_W(16)) bif ();
  bit1_master_if #(.CNT_W(16)) bif3 ();

  bit1_master #(.READ_LATENCY(1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif.master));
  bit1_master #(.READ_LATENCY(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bif3.master));

  int total = 0;
  int bad = 0;

  // ---- PIO models (own state, not reset by reset_n) ----
  logic p_out = 1'b0, p_dir = 1'b0, q_out = 1'b0, q_dir = 1'b0, ext = 1'b0;
  logic rd1 = 1'b0;
  logic [2:0] rd3 = 3'd0;
  wire pin  = p_dir ? p_out : ext;
  wire pin3 = q_dir ? q_out : ext;
  assign bif.m_readdata  = {31'd0, rd1};
  assign bif3.m_readdata = {31'd0, rd3[2]};

  always @(posedge clk) begin
    if (bif.m_chipselect && !bif.m_write_n) begin
      case (bif.m_address)
        3'd0: p_out <= bif.m_writedata[0];
        3'd1: p_dir <= bif.m_writedata[0];
        3'd4: if (bif.m_writedata[0]) p_out <= 1'b1;
        3'd5: if (bif.m_writedata[0]) p_out <= 1'b0;
        default: ;
      endcase
    end
    if (bif3.m_chipselect && !bif3.m_write_n) begin
      case (bif3.m_address)
        3'd0: q_out <= bif3.m_writedata[0];
        3'd1: q_dir <= bif3.m_writedata[0];
        3'd4: if (bif3.m_writedata[0]) q_out <= 1'b1;
        3'd5: if (bif3.m_writedata[0]) q_out <= 1'b0;
        default: ;
      endcase
    end
    rd1 <= pin;
    rd3 <= {rd3[1:0], pin3};
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---- scoreboard ----
  typedef struct { logic [1:0] op; logic exp; int len; int acc; } sb_t;
  typedef struct { int addr; int wd; int c; } wr_t;
  sb_t sbq[$];
  wr_t wq[$];
  int  cyc = 0, acc_cnt = 0, rsp_cnt = 0;
  logic exp_rd = 1'b0;
  int  run = 0, last_run = 0, run3 = 0, last_run3 = 0, hi_cnt = 0;

  // Accept monitor: builds the expected response of each accepted command.
  initial forever begin
    @(posedge clk);
    if (reset_n && bif.cmd_valid && bif.cmd_ready) begin
      sb_t e;
      int n;
      e.op  = bif.cmd_op;
      e.exp = (bif.cmd_op == 2'd2) ? exp_rd : 1'b0;
      n     = (bif.cmd_data == 16'd0) ? 1 : int'(bif.cmd_data);
      case (bif.cmd_op)
        2'd2:    e.len = 2;
        2'd3:    e.len = n + 1;
        default: e.len = 1;
      endcase
      e.acc = cyc + 1;
      sbq.push_back(e);
      acc_cnt++;
    end
    cyc++;
  end

  // Response/bus monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (bif.rsp_valid) begin
      rsp_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("rsp_data", int'(bif.rsp_data), int'(e.exp));
        chk("rsp_latency", cyc - e.acc, e.len);
      end
    end
    if (!bif.m_chipselect) begin
      chk("bus_idle", {bif.m_address, bif.m_write_n, (bif.m_writedata != 32'd0)},
          {3'd0, 1'b1, 1'b0});
    end
    if (bif.m_chipselect && !bif.m_write_n) begin
      wr_t w;
      w.addr = int'(bif.m_address);
      w.wd   = int'(bif.m_writedata);
      w.c    = cyc;
      wq.push_back(w);
    end
    if (bif.m_chipselect && bif.m_write_n) run++;
    else if (run != 0) begin last_run = run; run = 0; end
    if (bif3.m_chipselect && bif3.m_write_n) run3++;
    else if (run3 != 0) begin last_run3 = run3; run3 = 0; end
    if (pin) hi_cnt++;
  end

  // Issue one command to the latency-1 instance and wait for its response.
  task automatic issue(input logic [1:0] op, input logic [15:0] data, input logic exp);
    int k;
    k = 0;
    @(negedge clk);
    while (!bif.cmd_ready && k < 1000) begin @(negedge clk); k++; end
    if (k >= 1000) chk("ready_timeout", 0, 1);
    exp_rd = exp;
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_data  = data;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    k = 0;
    while (sbq.size() != 0 && k < 70000) begin @(negedge clk); k++; end
    if (k >= 70000) chk("rsp_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Command on the latency-3 instance; returns rsp_data.
  task automatic do3(input logic [1:0] op, input logic [15:0] data, output int rd);
    int k;
    @(negedge clk);
    bif3.cmd_valid = 1'b1;
    bif3.cmd_op    = op;
    bif3.cmd_data  = data;
    @(negedge clk);
    bif3.cmd_valid = 1'b0;
    k = 0;
    while (!bif3.rsp_valid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("rsp3_timeout", 0, 1);
    rd = int'(bif3.rsp_data);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_test(input logic [15:0] n, input int exp_hi);
    wq.delete();
    hi_cnt = 0;
    issue(2'd3, n, 1'b0);
    repeat (2) @(negedge clk);
    chk("pulse_high_cycles", hi_cnt, exp_hi);
    chk("pulse_write_count", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("pulse_set_addr", wq[0].addr, 4);
      chk("pulse_clr_addr", wq[1].addr, 5);
      chk("pulse_set_wd", wq[0].wd, 1);
      chk("pulse_set_to_clr", wq[1].c - wq[0].c, exp_hi);
    end
  endtask

  initial begin
    int r3, a0, r0;
    bif.cmd_valid = 1'b0; bif.cmd_op = 2'd0; bif.cmd_data = 16'd0;
    bif3.cmd_valid = 1'b0; bif3.cmd_op = 2'd0; bif3.cmd_data = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(bif.cmd_ready), 1);
    chk("rst_rsp_valid", int'(bif.rsp_valid), 0);
    chk("rst_rsp_data", int'(bif.rsp_data), 0);
    chk("rst_chipselect", int'(bif.m_chipselect), 0);
    chk("rst_write_n", int'(bif.m_write_n), 1);
    chk("rst3_cmd_ready", int'(bif3.cmd_ready), 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // SET_DIR 1: a single write to DIR with data 1.
    wq.delete();
    issue(2'd0, 16'd1, 1'b0);
    chk("setdir_writes", wq.size(), 1);
    if (wq.size() == 1) begin
      chk("setdir_addr", wq[0].addr, 1);
      chk("setdir_wd", wq[0].wd, 1);
    end
    chk("pio_dir", int'(p_dir), 1);

    // WRITE then READ back, both polarities.
    issue(2'd1, 16'd1, 1'b0);
    issue(2'd2, 16'd0, 1'b1);
    chk("read_cs_cycles", last_run, 2);
    issue(2'd1, 16'd0, 1'b0);
    issue(2'd2, 16'd0, 1'b0);
    chk("rsp_data_read0", int'(bif.rsp_data), 0);

    // Input direction, externally driven pin.
    issue(2'd0, 16'd0, 1'b0);
    ext = 1'b1;
    issue(2'd2, 16'd0, 1'b1);
    issue(2'd1, 16'd0, 1'b0);
    chk("rsp_data_cleared", int'(bif.rsp_data), 0);

    // Same read on the latency-3 instance.
    do3(2'd2, 16'd0, r3);
    chk("lat3_read1", r3, 1);
    chk("lat3_cs_cycles", last_run3, 4);
    ext = 1'b0;
    do3(2'd2, 16'd0, r3);
    chk("lat3_read0", r3, 0);

    // Pulses with the pin as output.
    issue(2'd0, 16'd1, 1'b0);
    pulse_test(16'd5, 5);
    pulse_test(16'd0, 1);
    pulse_test(16'd1, 1);
    pulse_test(16'd2, 2);

    // cmd_valid held with rotating ops; only ready cycles accept.
    issue(2'd1, 16'd1, 1'b0);
    a0 = acc_cnt;
    r0 = rsp_cnt;
    exp_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bif.cmd_valid = 1'b1;
      bif.cmd_op    = 2'(i % 3);
      bif.cmd_data  = 16'd1;
    end
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("stream_rsp_eq_acc", rsp_cnt - r0, acc_cnt - a0);
    chk("stream_accepted", (acc_cnt - a0 >= 8) ? 1 : 0, 1);
    chk("stream_sb_empty", sbq.size(), 0);

    // Reset in the middle of a long pulse hold.
    @(negedge clk);
    bif.cmd_valid = 1'b1; bif.cmd_op = 2'd3; bif.cmd_data = 16'd100;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_chipselect", int'(bif.m_chipselect), 0);
    chk("midrst_write_n", int'(bif.m_write_n), 1);
    chk("midrst_rsp_valid", int'(bif.rsp_valid), 0);
    sbq.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", int'(bif.cmd_ready), 1);
    issue(2'd1, 16'd0, 1'b0);
    issue(2'd2, 16'd0, 1'b0);
    chk("postrst_read", int'(bif.rsp_data), 0);
    chk("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
